// File: rtl/cordic_rotator.sv
// Rotation-mode CORDIC computing cos/sin of a Q3.13 angle. Stepped by an external
// iteration counter k: two clocks per iteration, k == 20 is the terminal count.
module cordic_rotator #(
    parameter int W  = 16,
    parameter int IW = 19
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic signed [W-1:0] angle,
    input  logic        [4:0]   k,
    output logic signed [W-1:0] cos_out,
    output logic signed [W-1:0] sin_out,
    output logic                busy,
    output logic                done,
    output logic                range_err
);

    localparam logic signed [IW-1:0] K_INIT  = IW'(9949);
    localparam logic signed [IW-1:0] ANG_MAX = IW'(12868);
    localparam logic signed [IW-1:0] ANG_MIN = -ANG_MAX;
    localparam logic signed [IW-1:0] OUT_MAX = IW'((1 << (W - 1)) - 1);
    localparam logic signed [IW-1:0] OUT_MIN = -OUT_MAX - IW'(1);
    localparam logic        [4:0]    K_LAST  = 5'd20;

    function automatic logic signed [IW-1:0] atan_lut(input logic [4:0] idx);
        logic signed [IW-1:0] v;
        v = '0;
        case (idx)
            5'd0:    v = IW'(6434);
            5'd1:    v = IW'(3798);
            5'd2:    v = IW'(2007);
            5'd3:    v = IW'(1019);
            5'd4:    v = IW'(511);
            5'd5:    v = IW'(256);
            5'd6:    v = IW'(128);
            5'd7:    v = IW'(64);
            5'd8:    v = IW'(32);
            5'd9:    v = IW'(16);
            5'd10:   v = IW'(8);
            5'd11:   v = IW'(4);
            5'd12:   v = IW'(2);
            5'd13:   v = IW'(1);
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic signed [W-1:0] sat(input logic signed [IW-1:0] v);
        if (v > OUT_MAX)
            return OUT_MAX[W-1:0];
        else if (v < OUT_MIN)
            return OUT_MIN[W-1:0];
        else
            return v[W-1:0];
    endfunction

    logic signed [IW-1:0] x, y, z;
    logic signed [IW-1:0] xs, ys, at;
    logic                 phase;

    logic signed [IW-1:0] angle_ext;
    logic signed [IW-1:0] z_load;
    logic                 clamp;
    logic                 z_neg;

    always_comb begin
        angle_ext = IW'(angle);
        z_load    = angle_ext;
        clamp     = 1'b0;
        if (angle_ext > ANG_MAX) begin
            z_load = ANG_MAX;
            clamp  = 1'b1;
        end else if (angle_ext < ANG_MIN) begin
            z_load = ANG_MIN;
            clamp  = 1'b1;
        end
    end

    // d = +1 when z >= 0, so only the sign bit selects add vs subtract.
    assign z_neg = z[IW-1];

    // NOTE: every register below is assigned with <= so all updates in one
    // edge see the pre-edge values of x/y/z; blocking here would chain them.
    // NOTE: the shift/table pipeline registers are reset too; they are few
    // flops and keeping them deterministic avoids X on a mid-op reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x         <= '0;
            y         <= '0;
            z         <= '0;
            xs        <= '0;
            ys        <= '0;
            at        <= '0;
            phase     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            range_err <= 1'b0;
            cos_out   <= '0;
            sin_out   <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                // start wins over any in-flight or terminal step
                phase     <= 1'b0;
                x         <= K_INIT;
                y         <= '0;
                z         <= z_load;
                range_err <= clamp;
                busy      <= 1'b1;
            end else begin
                phase <= ~phase;
                if (busy) begin
                    if (k == K_LAST) begin
                        cos_out <= sat(x);
                        sin_out <= sat(y);
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else if (k < K_LAST) begin
                        if (!phase) begin
                            xs <= x >>> k;
                            ys <= y >>> k;
                            at <= atan_lut(k);
                        end else if (!z_neg) begin
                            x <= x - ys;
                            y <= y + xs;
                            z <= z - at;
                        end else begin
                            x <= x + ys;
                            y <= y - xs;
                            z <= z + at;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cordic_rotator.sv
// Scoreboard bench for cordic_rotator: the driver pushes expected results at each
// start, a monitor pops and compares on every done pulse.
module tb_cordic_rotator;

    localparam int W       = 16;
    localparam int TOL     = 8;
    localparam int LATENCY = 41;

    typedef struct {
        int c;
        int s;
        int re;
        int cyc;
    } exp_t;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic signed [W-1:0] angle = '0;
    logic        [4:0]   k;
    logic signed [W-1:0] cos_out, sin_out;
    logic                busy, done, range_err;

    int   tests      = 0;
    int   fails      = 0;
    int   cyc        = 0;
    int   done_count = 0;
    int   last_c     = 0;
    int   last_s     = 0;
    exp_t sb[$];
    exp_t mon_e;

    cordic_rotator #(.W(16), .IW(19)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .angle     (angle),
        .k         (k),
        .cos_out   (cos_out),
        .sin_out   (sin_out),
        .busy      (busy),
        .done      (done),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Iteration counter model: k = j after edges 2j and 2j+1, parks at 20,
    // and free-runs 0..20 while idle.
    logic run, ph;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k   <= 5'd20;
            run <= 1'b0;
            ph  <= 1'b0;
        end else if (start) begin
            k   <= 5'd0;
            run <= 1'b1;
            ph  <= 1'b0;
        end else if (run) begin
            ph <= ~ph;
            if (k == 5'd20)
                run <= 1'b0;
            else if (ph)
                k <= k + 5'd1;
        end else begin
            k <= (k == 5'd20) ? 5'd0 : k + 5'd1;
        end
    end

    task automatic check(input string name, input int act, input int exp, input int tol);
        tests++;
        if (act - exp > tol || exp - act > tol) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d",
                     name, act, exp, tol, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            done_count++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending result", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("done_cycle", cyc, mon_e.cyc, 0);
                check("cos_out", int'(cos_out), mon_e.c, TOL);
                check("sin_out", int'(sin_out), mon_e.s, TOL);
                check("range_err_at_done", int'(range_err), mon_e.re, 0);
                check("busy_at_done", int'(busy), 0, 0);
                last_c = mon_e.c;
                last_s = mon_e.s;
            end
        end
    end

    // Drives a start pulse sampled at the next posedge; an unfinished op is aborted.
    task automatic do_start(input int a, input int ec, input int es, input int ere,
                            input bit chk_busy);
        exp_t e;
        bit   ok;
        @(negedge clk);
        #1;
        angle = W'(a);
        start = 1'b1;
        if (sb.size() != 0) void'(sb.pop_back());
        e.c   = ec;
        e.s   = es;
        e.re  = ere;
        e.cyc = cyc + 1 + LATENCY;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("range_err", int'(range_err), ere, 0);
        check("busy_after_start", int'(busy), 1, 0);
        check("cos_held", int'(cos_out), last_c, TOL);
        check("sin_held", int'(sin_out), last_s, TOL);
        if (chk_busy) begin
            ok = 1'b1;
            for (int i = 1; i <= 40; i++) begin
                @(posedge clk);
                #1;
                if (busy !== 1'b1) ok = 1'b0;
            end
            check("busy_edges_1_40", int'(ok), 1, 0);
        end
    endtask

    // Positions the next do_start so its start is sampled m edges after the last one.
    task automatic gap(input int m);
        repeat (m - 1) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("result_timeout", sb.size(), 0, 0);
        sb.delete();
    endtask

    initial begin
        int dc;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cos", int'(cos_out), 0, 0);
        check("rst_sin", int'(sin_out), 0, 0);
        check("rst_busy", int'(busy), 0, 0);
        check("rst_done", int'(done), 0, 0);
        check("rst_range_err", int'(range_err), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (45) @(negedge clk);
        check("idle_no_done", done_count, 0, 0);

        do_start(0, 16384, 0, 0, 1'b1);
        wait_idle();
        do_start(6434, 11585, 11585, 0, 1'b0);
        wait_idle();
        do_start(-4289, 14189, -8192, 0, 1'b0);
        wait_idle();
        do_start(20000, 0, 16384, 1, 1'b0);
        wait_idle();
        do_start(12868, 0, 16384, 0, 1'b0);
        wait_idle();

        // abort mid-operation with a fresh start
        do_start(0, 16384, 0, 0, 1'b0);
        gap(20);
        do_start(6434, 11585, 11585, 0, 1'b0);
        wait_idle();

        // start on the terminal edge: no done, outputs keep the pi/4 result
        do_start(0, 16384, 0, 0, 1'b0);
        gap(41);
        do_start(-4289, 14189, -8192, 0, 1'b0);
        wait_idle();

        // start in the done cycle: both results delivered
        do_start(6434, 11585, 11585, 0, 1'b0);
        gap(42);
        do_start(0, 16384, 0, 0, 1'b0);
        wait_idle();

        // async reset at edge 25 of an operation
        do_start(6434, 11585, 11585, 0, 1'b0);
        repeat (25) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0, 0);
        check("midrst_cos", int'(cos_out), 0, 0);
        check("midrst_sin", int'(sin_out), 0, 0);
        check("midrst_done", int'(done), 0, 0);
        sb.delete();
        last_c = 0;
        last_s = 0;
        dc = done_count;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("midrst_no_done", done_count, dc, 0);
        do_start(-4289, 14189, -8192, 0, 1'b0);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cordic_rotator.md
# cordic_rotator

Rotation-mode CORDIC datapath that computes cos/sin of a signed input angle. It sits directly downstream of the CORDIC iteration counter and uses its 5-bit count `k` (0–19 iterations, 20 = terminal) as the shift index and arctan-table address. Each iteration takes two clocks, matching the counter cadence: phase 0 registers the shifted operands and the table constant, phase 1 applies the add/subtract. Results are registered and flagged with a one-cycle `done` pulse.

## Interface
- `W`, 16: I/O data width. Angle is Q3.13; cos/sin are Q2.14.
- `IW`, 19: internal x/y/z width, sign-extended, with guard bits.
- `clk`  input  1  clock
- `rst_n`  input  1  reset; asynchronous, active-low
- `start`  input  1  single-cycle pulse, same pulse that drives the counter's `start`
- `angle`  input  W  signed Q3.13 radians; valid range ±12868 (±π/2)
- `k`  input  5  iteration index from the counter
- `cos_out`  output  W  signed Q2.14 cos(angle)
- `sin_out`  output  W  signed Q2.14 sin(angle)
- `busy`  output  1  high from the `start` edge until `done`
- `done`  output  1  one-cycle pulse when results update
- `range_err`  output  1  angle was clamped; held until next `start`

## Operation
- Reset: `cos_out`, `sin_out`, `busy`, `done`, `range_err` are 0. Internal x, y, z and the phase bit are 0.
- Phase bit:
  - Cleared on `start`; otherwise toggles every clock.
  - Must stay identical to the counter's toggle: phase 0 means the first clock of a given `k`.
- Load, on the edge that samples `start`:
  - x = 9949 (K = 0.6072529 in Q2.14), y = 0, z = angle sign-extended to IW.
  - If angle > 12868 or angle < −12868, z is clamped to ±12868 and `range_err` = 1; otherwise `range_err` = 0.
  - `busy` = 1.
- Phase 0, when busy and k < 20:
  - Register xs = x >>> k and ys = y >>> k (arithmetic shifts).
  - Register at = ATAN[k].
- Phase 1, when busy and k < 20:
  - d = sign of z (z ≥ 0 → +1).
  - x ← x − d·ys; y ← y + d·xs; z ← z − d·at.
- ATAN[k] = round(atan(2^−k)·2^13). Entries 0–13: 6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1. Entries 14–19 are 0.
- Terminal, first clock with busy and k == 20:
  - `cos_out` = x, `sin_out` = y, saturated to W bits signed (clamp to +32767/−32768).
  - `done` = 1 for one cycle; `busy` = 0.
- Outputs hold their values until the next terminal event; `start` alone does not clear them.
- k == 20 while not busy: ignored. The idle counter wrap must not produce `done`.
- `start` while busy: aborts the current operation and reloads from the new `angle`. No `done` is issued for the aborted one.
- `start` in the same cycle as the terminal condition: `start` wins. Reload, no `done`, outputs unchanged.
- Async reset mid-operation: everything returns to reset values immediately, with no `done`.

## Timing
- Edge 0 samples `start`. After edges 2j and 2j+1, k = j.
- Iteration j: phase-0 latch at edge 2j+1, update at edge 2j+2, for j = 0..19.
- Edge 41 sees k = 20. `cos_out`, `sin_out` and `done` are valid after edge 41 and `busy` falls. Latency is 41 clocks.
- `done` is high for exactly one cycle, cycle 41–42.
- Back-to-back operation: earliest next `start` is any cycle after `done`. A `start` coincident with `done` is legal and follows the start-wins rule for the following edge.
- No combinational path from inputs to outputs. All outputs are registered.

## Test plan
- Reset and idle: hold rst_n low, then release with k cycling idle → all outputs 0 and `done` never pulses.
- angle = 0, start at edge 0 → `done` after edge 41; cos_out = 16384 ±8, sin_out = 0 ±8; busy high for edges 1–40; range_err = 0.
- angle = 6434 (π/4) → cos_out = 11585 ±8 and sin_out = 11585 ±8. Angle = −4289 (−π/6) → cos_out = 14189 ±8, sin_out = −8192 ±8.
- angle = 20000 → range_err = 1 after edge 0; result equals the angle = 12868 case: cos_out = 0 ±8, sin_out = 16384 ±8.
- Restart: start with angle = 0, then start again at edge 20 with angle = 6434 → a single `done`, 41 edges after the second start, carrying π/4 results.
- Reset mid-op: assert rst_n at edge 25 of an operation → busy = 0 and outputs = 0 immediately. No `done` follows. A fresh start afterwards completes normally.
